// File: rtl/dram_port_arb_pkg.sv
// Shared encodings and default widths for the DRAM port arbiter.
package dram_port_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } state_t;

   localparam logic OWNER_A = 1'b0;
   localparam logic OWNER_B = 1'b1;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/dram_port_arb_if.sv
// Requester, DRAM and status signals of the arbiter bundled as one interface.
// DRAM_ARB_STATS_EN adds the wait counters and their clear.
interface dram_port_arb_if
   import dram_port_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              a_req, a_we, a_gnt, a_rvalid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_din, a_dout;

   logic              b_req, b_we, b_gnt, b_rvalid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_din, b_dout;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_di, mem_do;
   logic              busy;

`ifdef DRAM_ARB_STATS_EN
   logic              stats_clr;
   logic [15:0]       a_wait_cnt, b_wait_cnt;
`endif

   modport slave (
`ifdef DRAM_ARB_STATS_EN
      input  stats_clr,
      output a_wait_cnt, b_wait_cnt,
`endif
      input  a_req, a_we, a_addr, a_din,
      input  b_req, b_we, b_addr, b_din,
      input  mem_do,
      output a_gnt, a_rvalid, a_dout,
      output b_gnt, b_rvalid, b_dout,
      output mem_we, mem_addr, mem_di, busy
   );

   modport master (
`ifdef DRAM_ARB_STATS_EN
      output stats_clr,
      input  a_wait_cnt, b_wait_cnt,
`endif
      output a_req, a_we, a_addr, a_din,
      output b_req, b_we, b_addr, b_din,
      output mem_do,
      input  a_gnt, a_rvalid, a_dout,
      input  b_gnt, b_rvalid, b_dout,
      input  mem_we, mem_addr, mem_di, busy
   );

endinterface

// File: rtl/dram_arb_rdpipe.sv
// Per-port read return: remembers a fired read for one cycle and gates DRAM data.
module dram_arb_rdpipe #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fire_rd,
   input  logic [DATA_W-1:0] mem_do,
   output logic              rvalid,
   output logic [DATA_W-1:0] dout
);

   logic rd_pend;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_pend <= 1'b0;
      else      rd_pend <= fire_rd;
   end

   assign rvalid = rd_pend;
   assign dout   = rd_pend ? mem_do : '0;

endmodule

// File: rtl/dram_port_arb.sv
// Registered-grant, burst-capped round-robin arbiter for the single-port DRAM.
// DRAM_ARB_STATS_EN adds per-port saturating wait-cycle counters.
module dram_port_arb
   import dram_port_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = 16
) (
   input  logic            clk,
   input  logic            rst,
   dram_port_arb_if.slave  bus
);

   localparam int             BW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);

   state_t        state;
   logic          last_owner;
   logic [BW-1:0] burst_cnt;
   logic          a_gnt_q, b_gnt_q;
   logic          fire_a, fire_b, cap;

   assign fire_a = a_gnt_q & bus.a_req;
   assign fire_b = b_gnt_q & bus.b_req;
   assign cap    = (burst_cnt == BURST_LAST);

   // Grants are registered alongside the state so they never glitch or overlap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         last_owner <= OWNER_B;
         burst_cnt  <= '0;
         a_gnt_q    <= 1'b0;
         b_gnt_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               burst_cnt <= '0;
               if (bus.a_req && (!bus.b_req || last_owner == OWNER_B)) begin
                  state <= OWN_A; a_gnt_q <= 1'b1; last_owner <= OWNER_A;
               end else if (bus.b_req) begin
                  state <= OWN_B; b_gnt_q <= 1'b1; last_owner <= OWNER_B;
               end
            end
            OWN_A: begin
               if (bus.a_req && !(cap && bus.b_req)) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end else begin
                  burst_cnt <= '0;
                  a_gnt_q   <= 1'b0;
                  if (bus.b_req) begin
                     state <= OWN_B; b_gnt_q <= 1'b1; last_owner <= OWNER_B;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            OWN_B: begin
               if (bus.b_req && !(cap && bus.a_req)) begin
                  burst_cnt <= burst_cnt + 1'b1;
               end else begin
                  burst_cnt <= '0;
                  b_gnt_q   <= 1'b0;
                  if (bus.a_req) begin
                     state <= OWN_A; a_gnt_q <= 1'b1; last_owner <= OWNER_A;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               burst_cnt <= '0;
               a_gnt_q   <= 1'b0;
               b_gnt_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_gnt = a_gnt_q;
   assign bus.b_gnt = b_gnt_q;
   assign bus.busy  = (state != IDLE);

   always_comb begin
      bus.mem_we   = 1'b0;
      bus.mem_addr = {ADDR_W{1'b0}};
      bus.mem_di   = {DATA_W{1'b0}};
      if (fire_a) begin
         bus.mem_we = bus.a_we; bus.mem_addr = bus.a_addr; bus.mem_di = bus.a_din;
      end else if (fire_b) begin
         bus.mem_we = bus.b_we; bus.mem_addr = bus.b_addr; bus.mem_di = bus.b_din;
      end
   end

   // Read data follows the requester that issued it, even across an ownership change.
   dram_arb_rdpipe #(.DATA_W(DATA_W)) u_rd_a (
      .clk(clk), .rst(rst), .fire_rd(fire_a & ~bus.a_we), .mem_do(bus.mem_do),
      .rvalid(bus.a_rvalid), .dout(bus.a_dout)
   );

   dram_arb_rdpipe #(.DATA_W(DATA_W)) u_rd_b (
      .clk(clk), .rst(rst), .fire_rd(fire_b & ~bus.b_we), .mem_do(bus.mem_do),
      .rvalid(bus.b_rvalid), .dout(bus.b_dout)
   );

`ifdef DRAM_ARB_STATS_EN
   logic [15:0] a_wait_q, b_wait_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_wait_q <= '0;
         b_wait_q <= '0;
      end else if (bus.stats_clr) begin
         a_wait_q <= '0;
         b_wait_q <= '0;
      end else begin
         if (bus.a_req && !a_gnt_q && a_wait_q != 16'hFFFF) a_wait_q <= a_wait_q + 16'd1;
         if (bus.b_req && !b_gnt_q && b_wait_q != 16'hFFFF) b_wait_q <= b_wait_q + 16'd1;
      end
   end

   assign bus.a_wait_cnt = a_wait_q;
   assign bus.b_wait_cnt = b_wait_q;
`endif

endmodule

// File: tb/tb_dram_port_arb.sv
// Directed bench for dram_port_arb (MAX_BURST=4) with a 1-cycle synchronous DRAM model.
module tb_dram_port_arb;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   dram_port_arb_if #(.ADDR_W(16), .DATA_W(8)) bus ();

   dram_port_arb #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   logic [7:0] tb_mem [0:255];
   logic       pre_we;
   logic [7:0] pre_addr, pre_data;

   always @(posedge clk) begin
      if (pre_we) tb_mem[pre_addr] <= pre_data;
      else if (bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_di;
      bus.mem_do <= tb_mem[bus.mem_addr[7:0]];
   end

   task automatic idle_inputs;
      bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_din = '0;
      bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_din = '0;
`ifdef DRAM_ARB_STATS_EN
      bus.stats_clr = 0;
`endif
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_we = 1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 0;
   endtask

   task automatic test_reset;
      rst = 1;
      idle_inputs();
      #2 rst = 0;
      #1;
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt, bus.busy, bus.mem_we, bus.a_rvalid, bus.b_rvalid, bus.a_dout, bus.b_dout} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want all zero",
                  {bus.a_gnt, bus.b_gnt, bus.busy, bus.mem_we, bus.a_rvalid, bus.b_rvalid, bus.a_dout, bus.b_dout});
      end
      repeat (2) @(negedge clk);
      rst = 1;
      @(negedge clk);
      n_chk++;
      if ({bus.busy, bus.a_gnt, bus.b_gnt} !== 3'b000) begin
         n_fail++; $display("FAIL reset_idle: got %b want 000", {bus.busy, bus.a_gnt, bus.b_gnt});
      end
   endtask

   task automatic test_single;
      do_reset();
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0020; bus.a_din = 8'hAA;
      #1;
      n_chk++;
      if ({bus.a_gnt, bus.mem_we} !== 2'b00) begin
         n_fail++; $display("FAIL single_latency: gnt,we got %b want 00", {bus.a_gnt, bus.mem_we});
      end
      @(negedge clk);
      n_chk++;
      if ({bus.a_gnt, bus.mem_we, bus.mem_addr, bus.mem_di} !== {1'b1, 1'b1, 16'h0020, 8'hAA}) begin
         n_fail++; $display("FAIL single_write: got %h want %h",
                            {bus.a_gnt, bus.mem_we, bus.mem_addr, bus.mem_di}, {1'b1, 1'b1, 16'h0020, 8'hAA});
      end
      @(negedge clk);
      bus.a_we = 0;
      #1;
      n_chk++;
      if ({bus.mem_we, bus.mem_addr} !== {1'b0, 16'h0020}) begin
         n_fail++; $display("FAIL single_read_bus: got %h want %h", {bus.mem_we, bus.mem_addr}, {1'b0, 16'h0020});
      end
      @(negedge clk);
      n_chk++;
      if ({bus.a_rvalid, bus.a_dout} !== {1'b1, 8'hAA}) begin
         n_fail++; $display("FAIL single_rdata: got %h want %h", {bus.a_rvalid, bus.a_dout}, {1'b1, 8'hAA});
      end
      bus.a_req = 0;
      @(negedge clk);
      n_chk++;
      if ({bus.a_rvalid, bus.a_dout, bus.busy} !== 10'd0) begin
         n_fail++; $display("FAIL single_done: rvalid,dout,busy got %h want 0", {bus.a_rvalid, bus.a_dout, bus.busy});
      end
   endtask

   task automatic test_tie;
      do_reset();
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0040; bus.a_din = 8'h01;
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h0041; bus.b_din = 8'h02;
      @(negedge clk);
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
         n_fail++; $display("FAIL tie_first: a,b gnt got %b want 10", {bus.a_gnt, bus.b_gnt});
      end
      @(negedge clk);
      bus.a_req = 0;
      @(negedge clk);
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt, bus.busy} !== 3'b011) begin
         n_fail++; $display("FAIL tie_handover: a,b,busy got %b want 011", {bus.a_gnt, bus.b_gnt, bus.busy});
      end
      @(negedge clk);
      bus.b_req = 0;
      @(negedge clk);
      // A alone so that A becomes last owner before the next tie
      bus.a_req = 1; bus.a_addr = 16'h0042;
      @(negedge clk);
      @(negedge clk);
      bus.a_req = 0;
      @(negedge clk);
      n_chk++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL tie_idle: busy got %b want 0", bus.busy);
      end
      bus.a_req = 1; bus.a_addr = 16'h0043;
      bus.b_req = 1; bus.b_addr = 16'h0044;
      @(negedge clk);
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin
         n_fail++; $display("FAIL tie_second: a,b gnt got %b want 01", {bus.a_gnt, bus.b_gnt});
      end
      @(negedge clk);
      bus.b_req = 0;
      @(negedge clk);
      @(negedge clk);
      bus.a_req = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_burst_cap;
      int         b_idx = 0;
      bit         a_done = 0, pfa = 0, pfb = 0, bubble_err = 0;
      int         log_n = 0;
      logic [31:0] log_own = '0;
      do_reset();
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h0030; bus.b_din = 8'hB0;
      for (int g = 0; g < 80; g++) begin
         @(negedge clk);
         if (pfb) begin
            b_idx++;
            if (b_idx == 16) bus.b_req = 0;
            else begin
               bus.b_addr = 16'(16'h0030 + b_idx);
               bus.b_din  = 8'(8'hB0 + b_idx);
            end
         end
         if (pfa) begin bus.a_req = 0; a_done = 1; end
         if (b_idx == 16) break;
         if (bus.b_gnt && b_idx == 1 && !a_done && !bus.a_req) begin
            bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0050; bus.a_din = 8'h55;
         end
         if (bus.busy !== 1'b1) bubble_err = 1;
         pfa = bus.a_gnt && bus.a_req;
         pfb = bus.b_gnt && bus.b_req;
         if (pfa || pfb) begin
            if (log_n < 32) log_own[log_n] = pfa;
            log_n++;
         end
      end
      n_chk++;
      if (b_idx != 16) begin n_fail++; $display("FAIL burst_timeout: b accesses got %0d want 16", b_idx); end
      n_chk++;
      if (log_n != 17) begin n_fail++; $display("FAIL burst_count: accesses got %0d want 17", log_n); end
      n_chk++;
      if (log_own[16:0] !== 17'h00010) begin
         n_fail++; $display("FAIL burst_order: A-slot map got %h want 00010", log_own[16:0]);
      end
      n_chk++;
      if (bubble_err) begin n_fail++; $display("FAIL burst_bubble: busy dropped got 1 want 0"); end
      for (int i = 0; i < 16; i++) begin
         n_chk++;
         if (tb_mem[8'h30 + i] !== 8'(8'hB0 + i)) begin
            n_fail++; $display("FAIL burst_mem[%0d]: got %h want %h", i, tb_mem[8'h30 + i], 8'(8'hB0 + i));
         end
      end
      n_chk++;
      if (tb_mem[8'h50] !== 8'h55) begin n_fail++; $display("FAIL burst_a_mem: got %h want 55", tb_mem[8'h50]); end
   endtask

   task automatic test_read_handover;
      do_reset();
      preload(8'h21, 8'h0F);
      @(negedge clk);
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0060; bus.a_din = 8'h01;
      @(negedge clk);
      @(negedge clk); bus.a_addr = 16'h0061;
      @(negedge clk); bus.a_addr = 16'h0062;
      @(negedge clk);
      bus.a_we = 0; bus.a_addr = 16'h0021;
      bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h0070; bus.b_din = 8'h77;
      @(negedge clk);
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.a_dout, bus.b_rvalid} !== {1'b0, 1'b1, 1'b1, 8'h0F, 1'b0}) begin
         n_fail++; $display("FAIL handover_rdata: got %b want %b",
                            {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.a_dout, bus.b_rvalid}, {1'b0, 1'b1, 1'b1, 8'h0F, 1'b0});
      end
      bus.a_req = 0;
      @(negedge clk);
      n_chk++;
      if (bus.a_rvalid !== 1'b0) begin n_fail++; $display("FAIL handover_oneshot: a_rvalid got %b want 0", bus.a_rvalid); end
      bus.b_req = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_async_reset;
      do_reset();
      preload(8'h81, 8'h5A);
      @(negedge clk);
      bus.b_req = 1; bus.b_we = 0; bus.b_addr = 16'h0030;
      @(negedge clk);
      @(negedge clk);
      bus.b_we = 1; bus.b_addr = 16'h0081; bus.b_din = 8'h99;
      #1;
      n_chk++;
      if ({bus.b_rvalid, bus.mem_we} !== 2'b11) begin
         n_fail++; $display("FAIL areset_pre: rvalid,we got %b want 11", {bus.b_rvalid, bus.mem_we});
      end
      #2 rst = 0;
      #1;
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_we, bus.busy} !== 6'd0) begin
         n_fail++; $display("FAIL areset_now: got %b want 000000",
                            {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_we, bus.busy});
      end
      @(negedge clk);
      bus.a_req = 1; bus.a_we = 0; bus.a_addr = 16'h0021;
      @(negedge clk);
      rst = 1;
      n_chk++;
      if (tb_mem[8'h81] !== 8'h5A) begin n_fail++; $display("FAIL areset_nowrite: got %h want 5a", tb_mem[8'h81]); end
      @(negedge clk);
      n_chk++;
      if ({bus.a_gnt, bus.b_gnt, bus.b_rvalid} !== 3'b100) begin
         n_fail++; $display("FAIL areset_tie: a,b,brv got %b want 100", {bus.a_gnt, bus.b_gnt, bus.b_rvalid});
      end
      @(negedge clk);
      bus.a_req = 0;
      repeat (3) @(negedge clk);
      bus.b_req = 0;
      repeat (2) @(negedge clk);
   endtask

`ifdef DRAM_ARB_STATS_EN
   task automatic test_stats;
      do_reset();
      n_chk++;
      if ({bus.a_wait_cnt, bus.b_wait_cnt} !== 32'd0) begin
         n_fail++; $display("FAIL stats_reset: got %h want 0", {bus.a_wait_cnt, bus.b_wait_cnt});
      end
      bus.a_req = 1; bus.a_we = 1; bus.a_addr = 16'h0090; bus.a_din = 8'h01;
      @(negedge clk);
      @(negedge clk);
      bus.a_req = 0; bus.stats_clr = 1;
      @(negedge clk);
      bus.stats_clr = 0;
      bus.a_req = 1; bus.b_req = 1; bus.b_we = 1; bus.b_addr = 16'h0091; bus.b_din = 8'h02;
      for (int g = 0; g < 20; g++) begin @(negedge clk); if (bus.a_gnt) break; end
      n_chk++;
      if ({bus.a_gnt, bus.a_wait_cnt, bus.b_wait_cnt} !== {1'b1, 16'd5, 16'd1}) begin
         n_fail++; $display("FAIL stats_count: gnt,a,b got %h want %h",
                            {bus.a_gnt, bus.a_wait_cnt, bus.b_wait_cnt}, {1'b1, 16'd5, 16'd1});
      end
      bus.b_req = 0;
      @(negedge clk);
      bus.a_req = 0; bus.stats_clr = 1;
      @(negedge clk);
      bus.stats_clr = 0;
      n_chk++;
      if ({bus.a_wait_cnt, bus.b_wait_cnt} !== 32'd0) begin
         n_fail++; $display("FAIL stats_clear: got %h want 0", {bus.a_wait_cnt, bus.b_wait_cnt});
      end
      bus.a_req = 1; bus.b_req = 1;
      force dut.a_wait_q = 16'hFFFD;
      #1 release dut.a_wait_q;
      for (int g = 0; g < 20; g++) begin @(negedge clk); if (bus.a_gnt) break; end
      n_chk++;
      if (bus.a_wait_cnt !== 16'hFFFF) begin
         n_fail++; $display("FAIL stats_sat: got %h want ffff", bus.a_wait_cnt);
      end
      bus.b_req = 0;
      @(negedge clk);
      bus.a_req = 0;
      repeat (2) @(negedge clk);
   endtask
`endif

   initial begin
      #100000;
      $display("FAIL watchdog: sim time expired before test end");
      $fatal(1, "watchdog");
   end

   initial begin
      pre_we = 0; pre_addr = '0; pre_data = '0;
      rst = 1;
      idle_inputs();
      test_reset();
      test_single();
      test_tie();
      test_burst_cap();
      test_read_handover();
      test_async_reset();
`ifdef DRAM_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dram_port_arb.md
Name: dram_port_arb

Overview:
- Two-requester arbiter in front of the single-port synchronous DRAM.
- Port A serves the core data path; port B serves the DMA external port (extdaddr/extdin/extdout/extwe).
- Replaces the ad-hoc bench muxes with a registered-grant, burst-capped, round-robin arbiter.
- Returns read data to the owning requester with a valid strobe.

Parameters:
ADDR_W, 16, address width of both ports and DRAM
DATA_W, 8, data width
MAX_BURST, 16, max consecutive granted accesses for one owner while the other port waits (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
a_req  in  1  port A access request; held until serviced
a_we  in  1  port A write enable (valid with a_req)
a_addr  in  ADDR_W  port A address
a_din  in  DATA_W  port A write data
a_gnt  out  1  port A owns DRAM this cycle
a_rvalid  out  1  port A read data valid
a_dout  out  DATA_W  port A read data
b_req, b_we, b_addr, b_din, b_gnt, b_rvalid, b_dout  same as port A, for port B (DMA)
mem_we  out  1  DRAM write enable
mem_addr  out  ADDR_W  DRAM address
mem_di  out  DATA_W  DRAM write data
mem_do  in  DATA_W  DRAM read data; 1-cycle synchronous read
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, OWN_A, OWN_B. a_gnt = (state==OWN_A); b_gnt = (state==OWN_B); both registered, never both high.
- Access fires in a cycle where x_gnt && x_req. mem_* is driven combinationally from the owner's inputs. Otherwise mem_we=0, mem_addr=0, mem_di=0.
- IDLE, single request: go to that port's OWN state next cycle. Grant latency is 1 cycle from req.
- IDLE, both request: grant the port that is not last_owner. last_owner resets to B, so A wins the first tie.
- OWN_X, x_req low: go to OWN_Y if y_req, else IDLE. No bubble cycle.
- OWN_X, x_req high: stay, with one exception. If burst_cnt == MAX_BURST-1 and y_req, switch to OWN_Y after this access.
- burst_cnt increments per fired access and clears on any state change. Width is clog2(MAX_BURST), minimum 1. MAX_BURST=1 gives strict alternation under contention.
- last_owner updates to X on entry to OWN_X.
- Reads: rd_pend_x is set for 1 cycle after a fired access with x_we=0.
  - x_rvalid = rd_pend_x.
  - x_dout = mem_do when rd_pend_x, else 0.
  - Read data arrives one cycle after the access, even if ownership has switched meanwhile.
- Writes: take effect at the fired edge. No response strobe.
- Requesters must not change addr/we/din while req is high and gnt is low.
- Reset (rst=0, any time): state=IDLE, last_owner=B, burst_cnt=0, rd_pend_*=0. All outputs 0. An in-flight read is dropped and produces no rvalid.

Optional Feature:
- Macro: DRAM_ARB_STATS_EN.
- When defined:
  - Adds outputs a_wait_cnt and b_wait_cnt, each 16 bits.
  - Each counts cycles with x_req && !x_gnt and saturates at 16'hFFFF.
  - Adds input stats_clr, which zeros both counters synchronously. stats_clr has priority over increment.
  - Counters reset to 0.
- When not defined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, OWN_A=2'd1, OWN_B=2'd2;
  - owner id constants OWNER_A=1'b0, OWNER_B=1'b1;
  - default ADDR_W and DATA_W.
- Natural sub-module: dram_arb_rdpipe. It is the per-port read-pending register plus the dout gating, instantiated twice.
- Arbitration FSM and burst counter stay in the top.

Test Plan:
1. Reset, then A alone writes 8'hAA to 16'h0020. Expect a_gnt 1 cycle after a_req, mem_we=1 with mem_addr=16'h0020 and mem_di=8'hAA. A then reads 16'h0020: expect a_rvalid 1 cycle after the access with a_dout=8'hAA.
2. Reset, then A and B request in the same cycle. Expect a_gnt first, then b_gnt on the cycle after a_req drops, with no IDLE bubble. On the next tie, expect B granted first.
3. MAX_BURST=4, B holds b_req (DMA burst of 16 writes to 16'h0030..16'h003F), A requests at B's 2nd access. Expect B's 4th access, then A for 1 access, then B resumes. All 16 bytes must be present in DRAM afterwards.
4. A reads 16'h0021 (DRAM preloaded with 8'h0F) and drops req in the same cycle B's request is pending. Expect a_rvalid=1 with a_dout=8'h0F in the first b_gnt cycle, and b_rvalid=0 in that cycle.
5. Drive rst=0 asynchronously mid-burst, with a read in flight. Expect gnt, rvalid, mem_we and busy to go 0 immediately. After release with both requesting, expect A granted first.
6. With DRAM_ARB_STATS_EN defined: hold a_req blocked for 5 cycles. Expect a_wait_cnt=5. Then pulse stats_clr: expect 0. Preset the counter near FFFF and keep waiting: expect it to saturate at 16'hFFFF.
